// File: rtl/reg_dump_if.sv
// Valid/ready word stream carrying {address, data} pairs
// out of the register dump reader.
interface reg_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug scanner for the register file: walks a wrapping address
// range over one read port, streams {addr,data} and XORs a checksum.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  reg_dump_if.master        out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              fire;

  assign fire = valid_q && out.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    last_d  = last_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d  = last_addr;
          ra_d    = first_addr;
          sum_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // capture what the file shows this cycle
        data_d  = rd;
        addr_d  = ra_q;
        valid_d = 1'b1;
        sum_d   = sum_q ^ rd;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (fire) begin
          valid_d = 1'b0;
          if (addr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            ra_d    = ra_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ra            = ra_q;
  assign out.out_valid = valid_q;
  assign out.out_addr  = addr_q;
  assign out.out_data  = data_q;
  assign busy          = (state_q == S_READ) || (state_q == S_HOLD);
  assign done          = (state_q == S_DONE);
  assign checksum      = sum_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural
// register file on the read port.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [31:0] rf [32];

  reg_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .ra         (ra),
    .rd         (rd),
    .out        (bus.master),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  assign rd = (ra == 5'd0) ? 32'd0 : rf[ra];

  int          npass = 0;
  int          ntot  = 0;
  int          nw;
  int          ndone;
  logic [4:0]  wa [64];
  logic [31:0] wd [64];
  int          wt [64];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [4:0] f,
                      input logic [4:0] l,
                      input int stall,
                      input bit junk);
    int          k;
    int          held;
    logic [4:0]  ha;
    logic [31:0] hd;
    nw = 0;
    ndone = 0;
    held = 0;
    ha = '0;
    hd = '0;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.out_ready = 1'b1;
    chk("busy_after_start", busy, 1);
    chk("valid_latency", bus.out_valid, 0);
    k = 0;
    while (k < 400) begin
      if (done) begin
        ndone++;
        chk("busy_in_done", busy, 0);
        break;
      end
      if (junk) begin
        start = 1'b1;
        first_addr = f + 5'(k + 3);
        last_addr = f + 5'(k + 1);
      end
      if (bus.out_valid) begin
        if (held == 0) begin
          ha = bus.out_addr;
          hd = bus.out_data;
        end else begin
          chk("stall_addr", bus.out_addr, ha);
          chk("stall_data", bus.out_data, hd);
          chk("stall_ra", ra, ha);
        end
        if (held >= stall) begin
          bus.out_ready = 1'b1;
          if (nw < 64) begin
            wa[nw] = bus.out_addr;
            wd[nw] = bus.out_data;
            wt[nw] = k + 1;
          end
          nw++;
          held = 0;
        end else begin
          bus.out_ready = 1'b0;
          held++;
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      step();
      k++;
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    chk("scan_timeout", k < 400, 1);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_addr", bus.out_addr, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ra", ra, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", checksum, 0);

    rf[3] = 32'h11;
    rf[4] = 32'h22;
    rf[5] = 32'h44;
    scan(5'd3, 5'd5, 0, 0);
    chk("t1_count", nw, 3);
    chk("t1_a0", wa[0], 3);
    chk("t1_d0", wd[0], 32'h11);
    chk("t1_a1", wa[1], 4);
    chk("t1_d1", wd[1], 32'h22);
    chk("t1_a2", wa[2], 5);
    chk("t1_d2", wd[2], 32'h44);
    chk("t1_t0", wt[0], 2);
    chk("t1_t1", wt[1], 4);
    chk("t1_t2", wt[2], 6);
    chk("t1_done", ndone, 1);
    chk("t1_sum", checksum, 32'h77);
    step();
    chk("t1_done_clr", done, 0);
    chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_sum_hold", checksum, 32'h77);

    rf[30] = 32'hA;
    rf[31] = 32'hB;
    rf[1] = 32'hC;
    scan(5'd30, 5'd1, 0, 0);
    chk("t2_count", nw, 4);
    chk("t2_a0", wa[0], 30);
    chk("t2_d0", wd[0], 32'hA);
    chk("t2_a1", wa[1], 31);
    chk("t2_d1", wd[1], 32'hB);
    chk("t2_a2", wa[2], 0);
    chk("t2_d2", wd[2], 32'h0);
    chk("t2_a3", wa[3], 1);
    chk("t2_d3", wd[3], 32'hC);
    chk("t2_sum", checksum, 32'hD);
    step();

    rf[7] = 32'h70;
    rf[8] = 32'h80;
    scan(5'd7, 5'd8, 5, 0);
    chk("t3_count", nw, 2);
    chk("t3_a0", wa[0], 7);
    chk("t3_d0", wd[0], 32'h70);
    chk("t3_a1", wa[1], 8);
    chk("t3_d1", wd[1], 32'h80);
    chk("t3_t1_gap", wt[1] - wt[0], 7);
    chk("t3_sum", checksum, 32'hF0);
    step();

    for (int i = 0; i < 32; i++) rf[i] = i;
    scan(5'd0, 5'd31, 0, 0);
    chk("t4_count", nw, 32);
    for (int i = 0; i < 32; i++) begin
      chk("t4_addr", wa[i], i);
      chk("t4_data", wd[i], i);
    end
    chk("t4_done", ndone, 1);
    chk("t4_sum", checksum, 0);
    step();

    scan(5'd12, 5'd14, 0, 1);
    chk("t5_count", nw, 3);
    chk("t5_a0", wa[0], 12);
    chk("t5_a2", wa[2], 14);
    chk("t5_d1", wd[1], 13);
    chk("t5_sum", checksum, 32'hF);
    step();
    chk("t5_no_restart", busy, 0);
    scan(5'd9, 5'd9, 0, 0);
    chk("t5_single_cnt", nw, 1);
    chk("t5_single_a", wa[0], 9);
    chk("t5_single_d", wd[0], 9);
    chk("t5_single_sum", checksum, 9);
    step();

    first_addr = 5'd10;
    last_addr = 5'd12;
    bus.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t6_hold_valid", bus.out_valid, 1);
    chk("t6_hold_sum", checksum, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sum", checksum, 0);
    chk("t6_ra", ra, 0);
    nd = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done) nd++;
      step();
    end
    chk("t6_no_done", nd, 0);
    chk("t6_idle_valid", bus.out_valid, 0);
    scan(5'd3, 5'd3, 0, 0);
    chk("t6_new_cnt", nw, 1);
    chk("t6_new_a", wa[0], 3);
    chk("t6_new_d", wd[0], 3);
    chk("t6_new_done", ndone, 1);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential debug reader for the 32x32 register file. It drives one combinational read port and scans an inclusive, wrapping address range.
- It streams each {address, data} pair out over a valid/ready handshake and keeps a running XOR checksum.
- It sits beside the datapath and owns one read-address input of the register file. It never writes the file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; the scan wraps modulo 2^ADDR_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  starts a scan; sampled only in IDLE
- first_addr  input  ADDR_W  first address of the scan; latched on an accepted start
- last_addr  input  ADDR_W  last address of the scan (inclusive); latched on an accepted start
- ra  output  ADDR_W  register-file read address (registered)
- rd  input  DATA_W  register-file read data; combinational from ra, and reads 0 when ra=0
- out_valid  output  1  out_addr/out_data hold a valid word
- out_ready  input  1  downstream accepts the word
- out_addr  output  ADDR_W  address of the emitted word
- out_data  output  DATA_W  data of the emitted word
- busy  output  1  high from the accepted start until DONE is entered
- done  output  1  one-cycle pulse when the scan completes
- checksum  output  DATA_W  XOR of all words captured in the current or last scan

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) forces:
  - state=IDLE
  - ra=0, out_valid=0, out_addr=0, out_data=0
  - busy=0, done=0, checksum=0, latched last=0
  - rst has priority over every other input.
- Reset mid-scan aborts the scan immediately. No done pulse is produced, and any pending word is dropped.
- IDLE:
  - When start=1, latch last_addr, set ra<=first_addr, checksum<=0, busy<=1, and go to READ.
  - When start=0, hold all outputs. checksum retains the last scan's value.
- READ (one cycle):
  - out_data<=rd, out_addr<=ra, out_valid<=1, checksum<=checksum^rd.
  - Go to HOLD.
- HOLD:
  - out_valid stays 1, and out_addr/out_data stay stable, until out_valid && out_ready at an edge.
  - On that edge, out_valid<=0.
  - If out_addr==latched last, go to DONE.
  - Otherwise ra<=ra+1 (modulo 2^ADDR_W, so 31 wraps to 0) and go to READ.
- DONE (one cycle):
  - done=1 and busy=0 during this cycle.
  - Next state is IDLE, with done<=0.
- Latency:
  - start accepted at edge N.
  - rd is sampled at edge N+1.
  - out_valid=1 after edge N+1.
  - Best-case throughput is one word per 2 cycles with out_ready tied high.
- Word count is ((last-first) mod 2^ADDR_W)+1:
  - first==last gives 1 word.
  - first=last+1 gives all 32 words.
- start while busy or in DONE is ignored, including any change on first_addr/last_addr.
- out_ready while out_valid=0 has no effect.
- Coherency with concurrent writes:
  - The captured data is the file content combinationally visible during the READ cycle.
  - A write committed at the same edge that samples rd is not captured.
- Address 0 is emitted as data 0, because the file hardwires x0.
- busy and done are never high in the same cycle. done is high for exactly one cycle per completed scan.

Test Plan:
- Range 3..5, out_ready=1, file preloaded rf[3]=0x11, rf[4]=0x22, rf[5]=0x44:
  - Emits (3,0x11), (4,0x22), (5,0x44) on cycles N+2, N+4, N+6.
  - done pulses once, and checksum=0x77.
- Wrap range 30..1, rf[30]=0xA, rf[31]=0xB, rf[1]=0xC:
  - Emits addresses 30, 31, 0, 1 with data 0xA, 0xB, 0x0, 0xC.
  - checksum=0xD.
- Backpressure: range 7..8, out_ready low for 5 cycles after each out_valid:
  - out_addr/out_data stay stable while stalled.
  - Exactly 2 transfers, and ra does not advance until the handshake.
- Full scan first=0, last=31, with rf[i]=i for i>0:
  - 32 transfers in address order 0..31, then done.
  - checksum=0 (XOR of 0..31).
- start pulses during a scan with different first_addr/last_addr values:
  - Ignored; the original range completes unchanged.
  - Then first=last=9 gives a single word, (9, rf[9]).
- rst asserted while in HOLD:
  - Next cycle out_valid=0, busy=0, checksum=0.
  - No done pulse, and a new start works normally.
